// File: rtl/frame_loader.sv
// Picture stepper and frame loader: streams the ROWS pattern words of the
// current picture to a pipelined Wishbone slave, with ack tracking and timeout.
module frame_loader #(
  parameter int WB_DATA_WIDTH   = 32,
  parameter int ROWS            = 8,
  parameter int NUM_PICS        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255,
  localparam int WB_ADDR_WIDTH  = $clog2(ROWS),
  localparam int WB_SEL_WIDTH   = WB_DATA_WIDTH / 8,
  localparam int PIC_W          = $clog2(NUM_PICS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_next,
  input  logic                             i_prev,
  input  logic                             i_load,
  input  logic [PIC_W-1:0]                 i_sel,
  output logic [PIC_W-1:0]                 o_pic_num,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err,
  output logic [PIC_W+WB_ADDR_WIDTH-1:0]   o_pat_addr,
  input  logic [WB_DATA_WIDTH-1:0]         i_pat_data,
  output logic                             o_wb_cyc,
  output logic                             o_wb_stb,
  output logic                             o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0]         o_wb_addr,
  output logic [WB_SEL_WIDTH-1:0]          o_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]         o_wb_wdata,
  input  logic                             i_wb_ack,
  input  logic                             i_wb_stall,
  input  logic                             i_wb_err,
  input  logic [WB_DATA_WIDTH-1:0]         i_wb_rdata
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [PIC_W-1:0] pic;
  logic [PIC_W-1:0] load_pic;
  logic [PIC_W-1:0] pic_nxt;
  logic             next_q;
  logic             prev_q;
  logic [CW-1:0]    issue_row;
  logic [CW-1:0]    ack_cnt;
  logic [CW-1:0]    outst;
  logic [TW-1:0]    tmo;
  logic             pending;
  logic             done_q;
  logic             err_q;

  logic next_rise;
  logic prev_rise;
  logic ev;
  logic cyc;
  logic stb;
  logic beat;
  logic ack;
  logic last_beat;
  logic fin;
  logic abort;
  logic unused_bits;

  assign next_rise = i_next & ~next_q;
  assign prev_rise = i_prev & ~prev_q;
  assign ev        = i_load | next_rise | prev_rise;

  // i_load wins over i_next, which wins over i_prev
  always_comb begin
    pic_nxt = pic;
    if (i_load)
      pic_nxt = i_sel;
    else if (next_rise)
      pic_nxt = (pic == PIC_W'(NUM_PICS - 1)) ? '0 : pic + 1'b1;
    else if (prev_rise)
      pic_nxt = (pic == '0) ? PIC_W'(NUM_PICS - 1) : pic - 1'b1;
  end

  assign cyc       = (state != IDLE);
  assign stb       = (state == ISSUE) && (outst != CW'(MAX_OUTSTANDING));
  assign beat      = stb & ~i_wb_stall;
  assign ack       = cyc & i_wb_ack;
  assign last_beat = beat && (issue_row == CW'(ROWS - 1));
  assign fin       = ack && (ack_cnt == CW'(ROWS - 1));
  assign abort     = cyc && (i_wb_err || (tmo == TW'(TIMEOUT)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pic       <= '0;
      load_pic  <= '0;
      next_q    <= 1'b0;
      prev_q    <= 1'b0;
      issue_row <= '0;
      ack_cnt   <= '0;
      outst     <= '0;
      tmo       <= '0;
      pending   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      next_q <= i_next;
      prev_q <= i_prev;
      pic    <= pic_nxt;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == IDLE) begin
        if (ev || pending) begin
          state     <= ISSUE;
          load_pic  <= pic_nxt;
          pending   <= 1'b0;
          issue_row <= '0;
          ack_cnt   <= '0;
          outst     <= '0;
          tmo       <= '0;
        end
      end else if (abort) begin
        // a request seen during the aborted load still gets its reload
        state     <= IDLE;
        err_q     <= 1'b1;
        pending   <= pending | ev;
        issue_row <= '0;
        ack_cnt   <= '0;
        outst     <= '0;
        tmo       <= '0;
      end else if (fin) begin
        done_q    <= 1'b1;
        issue_row <= '0;
        ack_cnt   <= '0;
        outst     <= '0;
        tmo       <= '0;
        if (pending || ev) begin
          state    <= ISSUE;
          load_pic <= pic_nxt;
          pending  <= 1'b0;
        end else begin
          state <= IDLE;
        end
      end else begin
        if (ev)
          pending <= 1'b1;
        issue_row <= issue_row + CW'(beat);
        ack_cnt   <= ack_cnt + CW'(ack);
        outst     <= outst + CW'(beat) - CW'(ack);
        tmo       <= ack ? '0 : tmo + 1'b1;
        if (last_beat)
          state <= DRAIN;
      end
    end
  end

  assign o_pic_num  = pic;
  assign o_busy     = cyc;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_wb_cyc   = cyc;
  assign o_wb_stb   = stb;
  assign o_wb_we    = cyc;
  assign o_wb_addr  = issue_row[WB_ADDR_WIDTH-1:0];
  assign o_pat_addr = {load_pic, issue_row[WB_ADDR_WIDTH-1:0]};
  assign o_wb_sel   = '1;
  assign o_wb_wdata = stb ? i_pat_data : '0;

  assign unused_bits = ^{i_wb_rdata, issue_row};

endmodule

// File: tb/tb_frame_loader.sv
// Randomized self-checking bench for frame_loader with a Wishbone slave
// model and a row/picture scoreboard.
module tb_frame_loader;

  localparam int DW   = 32;
  localparam int ROWS = 8;
  localparam int NP   = 4;
  localparam int MO   = 4;
  localparam int TO   = 255;
  localparam int AW   = 3;
  localparam int PW   = 2;
  localparam int PA   = PW + AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_next;
  logic          i_prev;
  logic          i_load;
  logic [PW-1:0] i_sel;
  logic [PW-1:0] o_pic_num;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [PA-1:0] o_pat_addr;
  logic [DW-1:0] i_pat_data;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [3:0]    o_wb_sel;
  logic [DW-1:0] o_wb_wdata;
  logic          i_wb_ack;
  logic          i_wb_stall;
  logic          i_wb_err;
  logic [DW-1:0] i_wb_rdata;

  frame_loader dut (
    .clk        (clk),
    .reset      (reset),
    .i_next     (i_next),
    .i_prev     (i_prev),
    .i_load     (i_load),
    .i_sel      (i_sel),
    .o_pic_num  (o_pic_num),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_pat_addr (o_pat_addr),
    .i_pat_data (i_pat_data),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_addr  (o_wb_addr),
    .o_wb_sel   (o_wb_sel),
    .o_wb_wdata (o_wb_wdata),
    .i_wb_ack   (i_wb_ack),
    .i_wb_stall (i_wb_stall),
    .i_wb_err   (i_wb_err),
    .i_wb_rdata (i_wb_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [PA-1:0] a);
    return {a, 3'b101, 8'h5A, 3'b011, a, 8'hC3};
  endfunction

  assign i_pat_data = pat(o_pat_addr);

  int n_checks = 0;
  int n_errors = 0;

  int pend_acks = 0;
  int max_out   = 0;
  int beats     = 0;
  int dones     = 0;
  int errs      = 0;
  bit hold_acks = 0;
  bit rand_ack  = 0;
  bit rand_stall = 0;
  int stall_row = 0;
  int stall_left = 0;
  int sb_q[$];
  int sb_pic = -1;
  int sb_row = 0;

  // one clock: observe outputs, then drive the slave for the next edge
  task automatic step();
    int ex;
    @(negedge clk);
    if (o_done) dones++;
    if (o_err) errs++;
    if (pend_acks == MO) begin
      n_checks++;
      if (o_wb_stb !== 1'b0) begin
        n_errors++;
        $display("FAIL outstanding_cap: stb=%b with %0d unacked, required 0",
                 o_wb_stb, pend_acks);
      end
    end
    i_wb_ack = 1'b0;
    if (pend_acks > 0 && !hold_acks &&
        (!rand_ack || $urandom_range(1, 0) == 1)) begin
      i_wb_ack = 1'b1;
      pend_acks--;
    end
    i_wb_stall = 1'b0;
    if (stall_left > 0 && o_wb_stb && o_wb_addr == AW'(stall_row)) begin
      i_wb_stall = 1'b1;
      stall_left--;
    end else if (rand_stall && $urandom_range(2, 0) == 0) begin
      i_wb_stall = 1'b1;
    end
    if (o_wb_stb && !i_wb_stall) begin
      beats++;
      pend_acks++;
      if (pend_acks > max_out) max_out = pend_acks;
      if (sb_row == 0) sb_pic = (sb_q.size() == 0) ? -1 : sb_q.pop_front();
      ex = sb_pic * ROWS + sb_row;
      n_checks++;
      if (sb_pic < 0 || o_pat_addr !== PA'(ex) || o_wb_addr !== AW'(sb_row) ||
          o_wb_wdata !== pat(PA'(ex)) || o_wb_we !== 1'b1 ||
          o_wb_cyc !== 1'b1) begin
        n_errors++;
        $display("FAIL beat: pat_addr=%0d addr=%0d wdata=%h we=%b cyc=%b, required pic=%0d row=%0d wdata=%h",
                 o_pat_addr, o_wb_addr, o_wb_wdata, o_wb_we, o_wb_cyc,
                 sb_pic, sb_row, pat(PA'(ex)));
      end
      sb_row = (sb_row + 1) % ROWS;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_next = 0; i_prev = 0; i_load = 0; i_sel = '0;
    i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_rdata = '0;
    pend_acks = 0; sb_q.delete(); sb_row = 0; stall_left = 0;
    hold_acks = 0; rand_ack = 0; rand_stall = 0;
    step();
    step();
    reset = 1'b0;
    step();
    beats = 0; dones = 0; errs = 0; max_out = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_next = 0; i_prev = 0; i_load = 0; i_sel = '0;
    i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_rdata = '0;
    step();
    step();
    n_checks++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err} !== 6'b0 ||
        o_wb_addr !== '0 || o_pat_addr !== '0 || o_pic_num !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b busy=%b done=%b err=%b addr=%0d pat=%0d pic=%0d, required all 0",
               o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err,
               o_wb_addr, o_pat_addr, o_pic_num);
    end
    n_checks++;
    if (o_wb_sel !== 4'hF) begin
      n_errors++;
      $display("FAIL sel: got %h, required f", o_wb_sel);
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (o_busy !== 1'b0 || beats !== 0) begin
      n_errors++;
      $display("FAIL no_auto_load: busy=%b beats=%0d, required 0 0", o_busy, beats);
    end
  endtask

  task automatic test_basic();
    beats = 0; dones = 0;
    i_next = 1; sb_q.push_back(1);
    step();
    i_next = 0;
    n_checks++;
    if (o_pic_num !== 2'd1 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_start: pic=%0d busy=%b, required 1 1", o_pic_num, o_busy);
    end
    for (int k = 0; k < 50 && dones < 1; k++) step();
    n_checks++;
    if (dones !== 1 || beats !== ROWS || o_wb_cyc !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_done: dones=%0d beats=%0d cyc=%b, required 1 8 0",
               dones, beats, o_wb_cyc);
    end
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (dones !== 1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_single_done: dones=%0d busy=%b, required 1 0", dones, o_busy);
    end
  endtask

  task automatic test_outstanding();
    beats = 0; dones = 0; max_out = 0;
    hold_acks = 1;
    i_next = 1; sb_q.push_back(2);
    step();
    i_next = 0;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (beats !== MO || o_wb_stb !== 1'b0 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL outstanding_hold: beats=%0d stb=%b busy=%b, required 4 0 1",
               beats, o_wb_stb, o_busy);
    end
    hold_acks = 0;
    for (int k = 0; k < 60 && dones < 1; k++) step();
    n_checks++;
    if (dones !== 1 || beats !== ROWS || max_out !== MO) begin
      n_errors++;
      $display("FAIL outstanding_finish: dones=%0d beats=%0d max_out=%0d, required 1 8 4",
               dones, beats, max_out);
    end
  endtask

  task automatic test_stall();
    int seen;
    seen = 0; beats = 0; dones = 0;
    stall_row = 2; stall_left = 3;
    i_next = 1; sb_q.push_back(3);
    step();
    i_next = 0;
    for (int k = 0; k < 60 && dones < 1; k++) begin
      step();
      if (i_wb_stall) begin
        seen++;
        n_checks++;
        if (o_wb_addr !== 3'd2 || o_wb_wdata !== pat(5'd26)) begin
          n_errors++;
          $display("FAIL stall_hold: addr=%0d wdata=%h, required 2 %h",
                   o_wb_addr, o_wb_wdata, pat(5'd26));
        end
      end
    end
    n_checks++;
    if (seen !== 3 || beats !== ROWS || dones !== 1) begin
      n_errors++;
      $display("FAIL stall_total: stalls=%0d beats=%0d dones=%0d, required 3 8 1",
               seen, beats, dones);
    end
  endtask

  task automatic test_pic_select();
    do_reset();
    i_prev = 1; sb_q.push_back(3);
    step();
    i_prev = 0;
    n_checks++;
    if (o_pic_num !== 2'd3) begin
      n_errors++;
      $display("FAIL prev_wrap: pic=%0d, required 3", o_pic_num);
    end
    for (int k = 0; k < 50 && dones < 1; k++) step();
    i_load = 1; i_sel = 2'd2; i_next = 1; sb_q.push_back(2);
    step();
    i_load = 0; i_next = 0;
    n_checks++;
    if (o_pic_num !== 2'd2) begin
      n_errors++;
      $display("FAIL load_priority: pic=%0d, required 2", o_pic_num);
    end
    for (int k = 0; k < 50 && dones < 2; k++) step();
    for (int k = 0; k < 12; k++) step();
    n_checks++;
    if (dones !== 2 || beats !== 2 * ROWS || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_event: dones=%0d beats=%0d busy=%b, required 2 16 0",
               dones, beats, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    gap = 0; beats = 0; dones = 0;
    i_load = 1; i_sel = 2'd1; sb_q.push_back(1);
    step();
    i_load = 0;
    step();
    step();
    i_next = 1;
    step();
    i_next = 0;
    n_checks++;
    if (o_pic_num !== 2'd2 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_step1: pic=%0d busy=%b, required 2 1", o_pic_num, o_busy);
    end
    step();
    i_next = 1;
    step();
    i_next = 0;
    sb_q.push_back(3);
    n_checks++;
    if (o_pic_num !== 2'd3) begin
      n_errors++;
      $display("FAIL busy_step2: pic=%0d, required 3", o_pic_num);
    end
    for (int k = 0; k < 80 && dones < 2; k++) begin
      step();
      if (dones < 2 && o_busy !== 1'b1) gap++;
    end
    n_checks++;
    if (dones !== 2 || beats !== 2 * ROWS || gap !== 0) begin
      n_errors++;
      $display("FAIL back_to_back: dones=%0d beats=%0d idle_gaps=%0d, required 2 16 0",
               dones, beats, gap);
    end
  endtask

  task automatic test_timeout();
    int n;
    beats = 0; dones = 0; errs = 0;
    hold_acks = 1;
    i_next = 1; sb_q.push_back(0);
    step();
    i_next = 0;
    n = 1;
    while (errs == 0 && n < 400) begin
      step();
      n++;
    end
    n_checks++;
    if (errs !== 1 || dones !== 0 || o_wb_cyc !== 1'b0 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_abort: errs=%0d dones=%0d cyc=%b busy=%b, required 1 0 0 0",
               errs, dones, o_wb_cyc, o_busy);
    end
    n_checks++;
    if (n < TO + 1 || n > TO + 3) begin
      n_errors++;
      $display("FAIL timeout_len: err after %0d cycles, required about %0d", n, TO + 2);
    end
    hold_acks = 0; pend_acks = 0; sb_q.delete(); sb_row = 0;
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (errs !== 1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pulse: errs=%0d busy=%b, required 1 0", errs, o_busy);
    end
  endtask

  task automatic test_wb_err();
    beats = 0; dones = 0; errs = 0;
    i_next = 1; sb_q.push_back(1);
    step();
    i_next = 0;
    step();
    step();
    i_wb_err = 1;
    i_prev = 1;
    @(negedge clk);
    i_wb_err = 0;
    i_prev = 0;
    if (o_err) errs++;
    n_checks++;
    if (errs !== 1 || o_wb_cyc !== 1'b0 || o_pic_num !== 2'd0) begin
      n_errors++;
      $display("FAIL wb_err: errs=%0d cyc=%b pic=%0d, required 1 0 0",
               errs, o_wb_cyc, o_pic_num);
    end
    i_wb_ack = 0; pend_acks = 0; sb_q.delete(); sb_row = 0;
    sb_q.push_back(0);
    beats = 0;
    for (int k = 0; k < 50 && dones < 1; k++) step();
    n_checks++;
    if (dones !== 1 || beats !== ROWS || errs !== 1) begin
      n_errors++;
      $display("FAIL err_pending_reload: dones=%0d beats=%0d errs=%0d, required 1 8 1",
               dones, beats, errs);
    end
  endtask

  task automatic test_reset_midload();
    i_next = 1; sb_q.push_back(1);
    step();
    i_next = 0;
    step();
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err} !== 6'b0 ||
        o_wb_addr !== '0 || o_pat_addr !== '0 || o_pic_num !== '0) begin
      n_errors++;
      $display("FAIL async_reset: cyc=%b stb=%b we=%b busy=%b done=%b err=%b addr=%0d pat=%0d pic=%0d, required all 0",
               o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err,
               o_wb_addr, o_pat_addr, o_pic_num);
    end
    i_wb_ack = 0; pend_acks = 0; sb_q.delete(); sb_row = 0;
    step();
    reset = 1'b0;
    beats = 0; dones = 0; errs = 0;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (o_busy !== 1'b0 || beats !== 0 || dones !== 0 || errs !== 0) begin
      n_errors++;
      $display("FAIL after_reset: busy=%0b beats=%0d dones=%0d errs=%0d, required 0 0 0 0",
               o_busy, beats, dones, errs);
    end
  endtask

  task automatic test_random();
    int exp_pic;
    int target;
    bit l, nx, pv;
    int sel;
    do_reset();
    exp_pic = 0; target = 0;
    rand_ack = 1; rand_stall = 1;
    for (int it = 0; it < 20; it++) begin
      step();
      l  = 1'($urandom_range(1, 0));
      nx = 1'($urandom_range(1, 0));
      pv = 1'($urandom_range(1, 0));
      if (!l && !nx && !pv) pv = 1;
      sel = $urandom_range(NP - 1, 0);
      if (l) exp_pic = sel;
      else if (nx) exp_pic = (exp_pic + 1) % NP;
      else exp_pic = (exp_pic + NP - 1) % NP;
      i_load = l; i_next = nx; i_prev = pv; i_sel = PW'(sel);
      sb_q.push_back(exp_pic);
      target++;
      step();
      i_load = 0; i_next = 0; i_prev = 0;
      n_checks++;
      if (o_pic_num !== PW'(exp_pic)) begin
        n_errors++;
        $display("FAIL rand_pic[%0d]: pic=%0d, required %0d", it, o_pic_num, exp_pic);
      end
      for (int k = 0; k < 300 && dones < target; k++) step();
      n_checks++;
      if (dones !== target) begin
        n_errors++;
        $display("FAIL rand_done[%0d]: dones=%0d, required %0d", it, dones, target);
      end
    end
    rand_ack = 0; rand_stall = 0;
    n_checks++;
    if (beats !== 20 * ROWS || max_out > MO || errs !== 0) begin
      n_errors++;
      $display("FAIL rand_totals: beats=%0d max_out=%0d errs=%0d, required 160 <=4 0",
               beats, max_out, errs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_outstanding();
    test_stall();
    test_pic_select();
    test_back_to_back();
    test_timeout();
    test_wb_err();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, meaning the width of the Wishbone data bus and of one pattern row.
REQ-002 SHALL have parameter ROWS, default 8, meaning the number of rows written per frame load (>=2).
REQ-003 SHALL have parameter NUM_PICS, default 4, meaning the number of selectable pictures (>=2).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of un-acked requests (1..ROWS).
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning the idle cycles without an ack before a load is aborted.
REQ-006 SHALL derive WB_ADDR_WIDTH=$clog2(ROWS), WB_SEL_WIDTH=WB_DATA_WIDTH/8 and PIC_W=$clog2(NUM_PICS).
REQ-007 SHALL have these ports, with clock and reset first: clk, input, 1, the one clock; all state updates on its rising edge.
REQ-008 reset, input, 1, asynchronous active-high reset.
REQ-009 i_next / i_prev, input, 1 each, level inputs; a rising edge on either steps the picture.
REQ-010 i_load, input, 1, one-cycle strobe to load picture i_sel.
REQ-011 i_sel, input, PIC_W, picture index captured on i_load.
REQ-012 o_pic_num, output, PIC_W, the current picture.
REQ-013 o_busy, output, 1, high while a load is in progress.
REQ-014 o_done, output, 1, one-cycle pulse when all ROWS acks have been received.
REQ-015 o_err, output, 1, one-cycle pulse on abort (i_wb_err or timeout).
REQ-016 o_pat_addr, output, PIC_W+WB_ADDR_WIDTH, {picture,row} index into the external combinational pattern table.
REQ-017 i_pat_data, input, WB_DATA_WIDTH, pattern word for o_pat_addr, valid in the same cycle.
REQ-018 o_wb_cyc, o_wb_stb, o_wb_we, outputs, 1 each, Wishbone pipelined master controls.
REQ-019 o_wb_addr, output, WB_ADDR_WIDTH; o_wb_sel, output, WB_SEL_WIDTH; o_wb_wdata, output, WB_DATA_WIDTH.
REQ-020 i_wb_ack, i_wb_stall, i_wb_err, inputs, 1 each; i_wb_rdata, input, WB_DATA_WIDTH, ignored.

Function
REQ-021 SHALL implement an FSM with states IDLE, ISSUE and DRAIN.
REQ-022 Picture step: a registered rising-edge detector on i_next SHALL increment the picture, and one on i_prev SHALL decrement it, each modulo NUM_PICS (wrapping NUM_PICS-1<->0).
REQ-023 Priority when events coincide in one cycle: i_load > i_next > i_prev; only one event SHALL take effect.
REQ-024 Any accepted event SHALL update o_pic_num on the next edge and request a load.
REQ-025 IDLE: on a load request, SHALL go to ISSUE and clear the issue counter, the ack counter and the outstanding counter.
REQ-026 ISSUE: SHALL drive o_wb_cyc=o_wb_stb=o_wb_we=1, o_wb_addr=issue row, o_pat_addr={pic,issue row} and o_wb_wdata=i_pat_data.
REQ-027 A beat occurs when stb && !i_wb_stall; each beat SHALL increment the issue row and the outstanding count.
REQ-028 stb SHALL be low whenever the outstanding count equals MAX_OUTSTANDING, or after the beat for row ROWS-1; this is the transition to DRAIN.
REQ-029 While stalled, the address and data SHALL stay constant.
REQ-030 Each i_wb_ack SHALL decrement the outstanding count and increment the ack count.
REQ-031 A beat and an ack in the same cycle SHALL leave the outstanding count unchanged.
REQ-032 o_wb_cyc SHALL remain high from the first beat until the final ack.
REQ-033 When the ack count reaches ROWS, the FSM SHALL return to IDLE, drop cyc/stb and pulse o_done for 1 cycle.
REQ-034 An event arriving while busy SHALL update o_pic_num immediately and set a single pending flag; later events only update o_pic_num.
REQ-035 The current load SHALL complete using the picture latched at its start.
REQ-036 On completion with the pending flag set, the FSM SHALL go to ISSUE on the next cycle without visiting IDLE; o_done still pulses.
REQ-037 The timeout counter SHALL reset on every ack and on load start, and count while cyc=1.
REQ-038 When the timeout counter reaches TIMEOUT, or on i_wb_err, the FSM SHALL drop cyc/stb in the next cycle, pulse o_err, clear all counters and return to IDLE.
REQ-039 On abort, o_done SHALL NOT pulse; a set pending flag SHALL be honoured.
REQ-040 o_wb_sel SHALL be all ones.
REQ-041 o_busy SHALL equal (state != IDLE).

Reset
REQ-042 Asserting reset SHALL asynchronously force state=IDLE, o_pic_num=0, all counters=0, pending=0, and the edge-detect registers=0.
REQ-043 Asserting reset SHALL asynchronously force o_wb_cyc=o_wb_stb=o_wb_we=0, o_busy=0, o_done=0, o_err=0, o_wb_addr=0 and o_pat_addr=0.
REQ-044 Reset mid-load SHALL abandon the transaction with no o_done/o_err pulse.
REQ-045 After deassertion, the block SHALL stay IDLE until an event; no automatic load.

Verification
REQ-046 Defaults, slave never stalls and acks 1 cycle after each beat, i_next rises -> o_pic_num=1, 8 beats on addresses 0..7 with data from pattern {1,0..7}, o_done pulses once, cyc deasserts after ack 8.
REQ-047 Slave withholds acks -> exactly 4 beats, then stb low until acks arrive; outstanding count never exceeds 4.
REQ-048 i_wb_stall held 3 cycles on row 2 -> o_wb_addr=2 and wdata stable throughout; no row is skipped or duplicated.
REQ-049 i_prev rises at pic 0 -> o_pic_num=3; i_load with i_sel=2 and i_next in the same cycle -> o_pic_num=2.
REQ-050 i_next twice during a load -> the first load completes with the old picture, then one reload of pic+2 follows back-to-back.
REQ-051 No ack for 255 cycles -> o_err pulses, o_done stays 0, cyc drops; reset asserted mid-load -> all outputs 0 with no clock edge needed.
